// File: rtl/fib_seq_ctrl.sv
// Fibonacci ROM sequencer: takes a (first_idx, count) job, walks the ROM and streams terms over valid/ready.
// Optional macro FIB_SEQ_WRAP_EN lets the index wrap from LAST_IDX back to 0 instead of rejecting such jobs.
module fib_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  first_idx,
  input  logic [5:0]  count,
  output logic [5:0]  rom_rdadr,
  input  logic [23:0] rom_rddat,
  output logic [23:0] out_dat,
  output logic [5:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [5:0] LAST_IDX = 6'd34;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [23:0] out_dat_q, out_dat_d;
  logic [5:0]  out_idx_q, out_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;
  logic        range_ok;
  logic [5:0]  next_idx;

`ifdef FIB_SEQ_WRAP_EN
  assign range_ok = (count != 6'd0) && (first_idx <= LAST_IDX) && (count <= (LAST_IDX + 6'd1));
  assign next_idx = (idx_q == LAST_IDX) ? 6'd0 : (idx_q + 6'd1);
`else
  // Last index of the job computed at 7 bits so first_idx+count cannot overflow.
  logic [6:0] last_job_idx;
  assign last_job_idx = {1'b0, first_idx} + {1'b0, count} - 7'd1;
  assign range_ok     = (count != 6'd0) && (last_job_idx <= {1'b0, LAST_IDX});
  assign next_idx     = idx_q + 6'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      remaining_q <= 6'd0;
      out_dat_q   <= 24'd0;
      out_idx_q   <= 6'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      out_dat_q   <= out_dat_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    out_dat_d   = out_dat_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            idx_d       = first_idx;
            remaining_d = count;
            err_d       = 1'b0;
            state_d     = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        out_dat_d   = rom_rddat;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        // Term is held untouched until the consumer takes it.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (remaining_q == 6'd1) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - 6'd1;
            idx_d       = next_idx;
            state_d     = FETCH;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_rdadr = idx_q;
  assign out_dat   = out_dat_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed self-checking bench for fib_seq_ctrl; the ROM is modelled here as entry i = Fib(i+1).
// Build with FIB_SEQ_WRAP_EN defined to exercise the wrap configuration.
module tb_fib_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  first_idx;
  logic [5:0]  count;
  logic [5:0]  rom_rdadr;
  logic [23:0] rom_rddat;
  logic [23:0] out_dat;
  logic [5:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  int compared;
  int mismatched;

  fib_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_idx (first_idx),
    .count     (count),
    .rom_rdadr (rom_rdadr),
    .rom_rddat (rom_rddat),
    .out_dat   (out_dat),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  function automatic logic [23:0] rom_word(input logic [5:0] a);
    logic [23:0] x, y, t;
    x = 24'd1;
    y = 24'd1;
    if (a > 6'd34) return 24'hABCDEF;
    for (int i = 0; i < int'(a); i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign rom_rddat = rom_word(rom_rdadr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue a one-cycle start from a negedge; returns at the negedge after the sampling edge.
  task automatic do_start(input logic [5:0] fi, input logic [5:0] cnt);
    start     = 1'b1;
    first_idx = fi;
    count     = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    compared++;
    if ({rom_rdadr, out_dat, out_idx, out_valid, busy, done, err} !== 40'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected %h",
               {rom_rdadr, out_dat, out_idx, out_valid, busy, done, err}, 40'd0);
    end
  endtask

  task automatic test_basic;
    logic [23:0] exp_dat [5] = '{24'd1, 24'd1, 24'd2, 24'd3, 24'd5};
    out_ready = 1'b1;
    do_start(6'd0, 6'd5);
    compared++;
    if ({busy, out_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL basic_fetch: got %b expected %b", {busy, out_valid}, 2'b10);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_dat, out_idx} !== {1'b1, exp_dat[k], 6'(k)}) begin
        mismatched++;
        $display("FAIL basic_term%0d: got v=%b d=%0d i=%0d expected v=1 d=%0d i=%0d",
                 k, out_valid, out_dat, out_idx, exp_dat[k], k);
      end
      @(negedge clk);
      compared++;
      if (k < 4) begin
        if ({out_valid, done} !== 2'b00) begin
          mismatched++;
          $display("FAIL basic_gap%0d: got v,done=%b expected 00", k, {out_valid, done});
        end
      end else begin
        if ({out_valid, done, err} !== 3'b010) begin
          mismatched++;
          $display("FAIL basic_done: got v,done,err=%b expected 010", {out_valid, done, err});
        end
      end
    end
    @(negedge clk);
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++;
      $display("FAIL basic_idle: got busy,done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    do_start(6'd10, 6'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_dat, out_idx} !== {1'b1, 24'd89, 6'd10}) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b d=%0d i=%0d expected v=1 d=89 i=10",
                 c, out_valid, out_dat, out_idx);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_gap: got v=%b expected 0", out_valid);
    end
    @(negedge clk);
    compared++;
    if ({out_valid, out_dat, out_idx} !== {1'b1, 24'd144, 6'd11}) begin
      mismatched++;
      $display("FAIL bp_term2: got v=%b d=%0d i=%0d expected v=1 d=144 i=11",
               out_valid, out_dat, out_idx);
    end
    @(negedge clk);
    compared++;
    if ({out_valid, done, err} !== 3'b010) begin
      mismatched++;
      $display("FAIL bp_done: got v,done,err=%b expected 010", {out_valid, done, err});
    end
    @(negedge clk);
  endtask

  // Rejected job: done+err in the cycle after start, no data, then idle with err held.
  task automatic test_range_error(input logic [5:0] fi, input logic [5:0] cnt);
    do_start(fi, cnt);
    compared++;
    if ({done, err, out_valid, busy} !== 4'b1101) begin
      mismatched++;
      $display("FAIL rerr_%0d_%0d: got done,err,v,busy=%b expected 1101",
               fi, cnt, {done, err, out_valid, busy});
    end
    @(negedge clk);
    compared++;
    if ({done, err, out_valid, busy} !== 4'b0100) begin
      mismatched++;
      $display("FAIL rerr_hold_%0d_%0d: got done,err,v,busy=%b expected 0100",
               fi, cnt, {done, err, out_valid, busy});
    end
  endtask

  // Job ending exactly at the last ROM entry must be accepted and clear a previous err.
  task automatic test_boundary;
    logic [23:0] exp_dat [5] = '{24'd1346269, 24'd2178309, 24'd3524578, 24'd5702887, 24'd9227465};
    out_ready = 1'b1;
    do_start(6'd30, 6'd5);
    compared++;
    if ({err, busy, out_valid} !== 3'b010) begin
      mismatched++;
      $display("FAIL bnd_accept: got err,busy,v=%b expected 010", {err, busy, out_valid});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_dat, out_idx} !== {1'b1, exp_dat[k], 6'(30 + k)}) begin
        mismatched++;
        $display("FAIL bnd_term%0d: got v=%b d=%0d i=%0d expected v=1 d=%0d i=%0d",
                 k, out_valid, out_dat, out_idx, exp_dat[k], 30 + k);
      end
      @(negedge clk);
    end
    compared++;
    if ({done, err} !== 2'b10) begin
      mismatched++;
      $display("FAIL bnd_done: got done,err=%b expected 10", {done, err});
    end
    @(negedge clk);
  endtask

`ifdef FIB_SEQ_WRAP_EN
  task automatic test_wrap;
    logic [23:0] exp_dat [6] = '{24'd1346269, 24'd2178309, 24'd3524578, 24'd5702887, 24'd9227465, 24'd1};
    logic [5:0]  exp_idx [6] = '{6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd0};
    out_ready = 1'b1;
    do_start(6'd30, 6'd6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_dat, out_idx} !== {1'b1, exp_dat[k], exp_idx[k]}) begin
        mismatched++;
        $display("FAIL wrap_term%0d: got v=%b d=%0d i=%0d expected v=1 d=%0d i=%0d",
                 k, out_valid, out_dat, out_idx, exp_dat[k], exp_idx[k]);
      end
      @(negedge clk);
    end
    compared++;
    if ({done, err} !== 2'b10) begin
      mismatched++;
      $display("FAIL wrap_done: got done,err=%b expected 10", {done, err});
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_busy_ignore;
    out_ready = 1'b1;
    do_start(6'd5, 6'd2);
    start     = 1'b1;
    first_idx = 6'd2;
    count     = 6'd3;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if ({out_valid, out_dat, out_idx} !== {1'b1, 24'd8, 6'd5}) begin
      mismatched++;
      $display("FAIL busy_term1: got v=%b d=%0d i=%0d expected v=1 d=8 i=5", out_valid, out_dat, out_idx);
    end
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({out_valid, out_dat, out_idx} !== {1'b1, 24'd13, 6'd6}) begin
      mismatched++;
      $display("FAIL busy_term2: got v=%b d=%0d i=%0d expected v=1 d=13 i=6", out_valid, out_dat, out_idx);
    end
    @(negedge clk);
    compared++;
    if ({done, err, out_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL busy_done: got done,err,v=%b expected 100", {done, err, out_valid});
    end
    @(negedge clk);
    compared++;
    if ({busy, done, out_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL busy_idle: got busy,done,v=%b expected 000", {busy, done, out_valid});
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    do_start(6'd0, 6'd3);
    @(negedge clk);
    compared++;
    if ({out_valid, out_dat} !== {1'b1, 24'd1}) begin
      mismatched++;
      $display("FAIL rmid_send: got v=%b d=%0d expected v=1 d=1", out_valid, out_dat);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({rom_rdadr, out_dat, out_idx, out_valid, busy, done, err} !== 40'd0) begin
      mismatched++;
      $display("FAIL rmid_async: got %h expected %h",
               {rom_rdadr, out_dat, out_idx, out_valid, busy, done, err}, 40'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    do_start(6'd3, 6'd1);
    compared++;
    if ({busy, out_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL rmid_restart: got busy,v=%b expected 10", {busy, out_valid});
    end
    @(negedge clk);
    compared++;
    if ({out_valid, out_dat, out_idx} !== {1'b1, 24'd3, 6'd3}) begin
      mismatched++;
      $display("FAIL rmid_term: got v=%b d=%0d i=%0d expected v=1 d=3 i=3", out_valid, out_dat, out_idx);
    end
    @(negedge clk);
    compared++;
    if ({done, err, out_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL rmid_done: got done,err,v=%b expected 100", {done, err, out_valid});
    end
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    first_idx  = 6'd0;
    count      = 6'd0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_range_error(6'd0, 6'd0);
    test_range_error(6'd35, 6'd1);
`ifdef FIB_SEQ_WRAP_EN
    test_range_error(6'd0, 6'd36);
    test_wrap();
`else
    test_range_error(6'd30, 6'd6);
`endif
    test_boundary();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
